branch_resolution_queue: RTL

Resolution-side partner of the branch prediction unit. Buffers every prediction issued at fetch (pc, history index, predicted target, predicted direction) in program order. When the execute stage resolves the oldest outstanding branch, the block compares actual and predicted outcomes and drives the `res_*` update bundle back to the predictor. On a misprediction it also issues a front-end redirect and discards all younger wrong-path entries.

---
 rtl/branch_resolution_queue.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolution_queue.sv
// Program-order queue of branch predictions; resolves the head against execute results.
// Outputs registered (resolve at edge N -> res/redir valid in cycle N+1); push refused when full, wrong-path pushes dropped.
package mmm_pkg;
   parameter int XLEN = 32;
   parameter int HLEN = 10;
endpackage

module branch_resolution_queue
   import mmm_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            pred_valid_i,
   input  logic [XLEN-1:0] pred_pc_i,
   input  logic [HLEN-1:0] pred_index_i,
   input  logic [XLEN-1:0] pred_target_i,
   input  logic            pred_taken_i,
   output logic            pred_ready_o,
   input  logic            exe_valid_i,
   input  logic            exe_taken_i,
   input  logic [XLEN-1:0] exe_target_i,
   output logic            res_valid_o,
   output logic [XLEN-1:0] res_pc_o,
   output logic [HLEN-1:0] res_index_o,
   output logic [XLEN-1:0] res_target_o,
   output logic            res_taken_o,
   output logic            res_mispredict_o,
   output logic            redir_valid_o,
   output logic [XLEN-1:0] redir_pc_o,
   output logic            empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [HLEN-1:0] index;
      logic [XLEN-1:0] target;
      logic            taken;
   } rec_t;

   rec_t            mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q,  count_d;

   logic            res_valid_q, res_valid_d;
   logic [XLEN-1:0] res_pc_q, res_pc_d;
   logic [HLEN-1:0] res_index_q, res_index_d;
   logic [XLEN-1:0] res_target_q, res_target_d;
   logic            res_taken_q, res_taken_d;
   logic            res_mis_q, res_mis_d;
   logic            redir_valid_q, redir_valid_d;
   logic [XLEN-1:0] redir_pc_q, redir_pc_d;

   rec_t            head;
   rec_t            push_rec;
   logic            push_req, push_acc, res_acc, mispredict;
   logic [XLEN-1:0] next_pc;

   assign pred_ready_o = (count_q != CNT_FULL);
   assign empty_o      = (count_q == '0);
   assign head         = mem_q[rd_ptr_q];

   always_comb begin
      push_rec        = '0;
      push_rec.pc     = pred_pc_i;
      push_rec.index  = pred_index_i;
      push_rec.target = pred_target_i;
      push_rec.taken  = pred_taken_i;

      push_req   = pred_valid_i && pred_ready_o && !flush_i;
      res_acc    = exe_valid_i && !empty_o && !flush_i;
      mispredict = res_acc &&
                   ((head.taken != exe_taken_i) ||
                    (head.taken && exe_taken_i && (head.target != exe_target_i)));
      next_pc    = exe_taken_i ? exe_target_i : head.pc + XLEN'(4);
      // A mispredict makes anything fetched this cycle wrong-path.
      push_acc   = push_req && !mispredict;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i || mispredict) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
         if (res_acc)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push_acc && !res_acc)      count_d = count_q + (PW+1)'(1);
         else if (res_acc && !push_acc) count_d = count_q - (PW+1)'(1);
      end
   end

   always_comb begin
      res_valid_d   = res_acc;
      res_pc_d      = '0;
      res_index_d   = '0;
      res_target_d  = '0;
      res_taken_d   = 1'b0;
      res_mis_d     = 1'b0;
      redir_valid_d = mispredict;
      redir_pc_d    = '0;
      if (res_acc) begin
         res_pc_d     = head.pc;
         res_index_d  = head.index;
         res_target_d = next_pc;
         res_taken_d  = exe_taken_i;
         res_mis_d    = mispredict;
         redir_pc_d   = next_pc;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_acc) mem_q[wr_ptr_q] <= push_rec;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         res_valid_q   <= 1'b0;
         res_pc_q      <= '0;
         res_index_q   <= '0;
         res_target_q  <= '0;
         res_taken_q   <= 1'b0;
         res_mis_q     <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         res_valid_q   <= res_valid_d;
         res_pc_q      <= res_pc_d;
         res_index_q   <= res_index_d;
         res_target_q  <= res_target_d;
         res_taken_q   <= res_taken_d;
         res_mis_q     <= res_mis_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
      end
   end

   assign res_valid_o      = res_valid_q;
   assign res_pc_o         = res_pc_q;
   assign res_index_o      = res_index_q;
   assign res_target_o     = res_target_q;
   assign res_taken_o      = res_taken_q;
   assign res_mispredict_o = res_mis_q;
   assign redir_valid_o    = redir_valid_q;
   assign redir_pc_o       = redir_pc_q;

endmodule
